interface_ifft_out: RTL and testbench
=====================================

Name: interface_ifft_out

Overview:
- Return-path driver for the audio spectral chain; the inverse of the forward FFT driver.
- Accepts a frame of N frequency bins from the spectral processing stage over a valid/ready stream.
- Loads the frame into the shared fft core, runs it in inverse direction, unloads the time-domain real part into a ping-pong playback buffer, and plays one sample per codec sample strobe.

Parameters:
- NB, 18, sample and bin component width.
- LOG_DEPTH, 9, log2 of frame length.
- N, 1<<LOG_DEPTH, frame length (512).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- bin_valid  in  1  bin_real/bin_imag valid.
- bin_real  in  NB  signed bin real part.
- bin_imag  in  NB  signed bin imaginary part.
- bin_ready  out  1  block accepts bin this cycle.
- core_start  out  1  one-cycle start pulse to fft core.
- core_log_depth  out  4  constant LOG_DEPTH.
- core_real_mode  out  1  constant 1.
- core_direction  out  1  constant 1 (inverse).
- core_ready  in  1  core idle.
- core_done  in  1  transform complete.
- core_output_scaling  in  4  shift count reported by core.
- core_address  out  LOG_DEPTH  core data address.
- core_write_enable  out  1  write bin at core_address.
- core_write_data  out  2*NB  {imag, real}.
- core_read_enable  out  1  request read at core_address.
- core_read_valid  in  1  core_read_data valid for current core_address.
- core_read_data  in  2*NB  {imag, real}.
- sample_strobe  in  1  one-cycle codec sample tick.
- sample_out  out  NB  signed time-domain sample to codec.
- sample_valid  out  1  pulse, one cycle after sample_strobe.
- underrun  out  1  sticky: strobe arrived with no full bank.

Behaviour:
- Reset (reset==0 at posedge): state LOAD, all counters 0, both banks empty, play_bank=0, fill_bank=0; outputs bin_ready=0, core_start=0, core_write_enable=0, core_read_enable=0, core_address=0, core_write_data=0, sample_out=0, sample_valid=0, underrun=0. Reset mid-frame discards all in-flight data; the core is not otherwise notified.
- FSM states: LOAD, START, WAIT_DONE, WAIT_BANK, UNLOAD.
- LOAD:
  - bin_ready=1.
  - On bin_valid&&bin_ready, register core_write_data={bin_imag,bin_real}, core_write_enable=1, core_address=load_idx; load_idx++.
  - After bin N-1 is accepted: bin_ready=0 next cycle, go to START.
  - Exactly N core writes per frame, addresses 0..N-1 in order.
- START: wait for core_ready=1, then core_start=1 for exactly one cycle; go to WAIT_DONE.
- WAIT_DONE: on core_done, latch scale=core_output_scaling; go to WAIT_BANK.
- WAIT_BANK: if bank[fill_bank] empty, go to UNLOAD with core_address=0 and core_read_enable=1.
- UNLOAD:
  - On each core_read_valid, write sat(real << scale) into bank[fill_bank][core_address], then core_address++.
  - On valid at address N-1: core_read_enable=0, mark bank full, toggle fill_bank, go to LOAD.
- Saturation: real part sign-extended, shifted left by scale, clamped to [-2^(NB-1), 2^(NB-1)-1] (0x20000..0x1FFFF for NB=18).
- Playback, concurrent with the FSM:
  - On sample_strobe with bank[play_bank] full: sample_out=bank[play_bank][play_idx] and sample_valid=1 next cycle; play_idx++.
  - At play_idx N-1: mark bank empty, toggle play_bank, play_idx=0.
  - On sample_strobe with bank[play_bank] not full: sample_out=0, sample_valid=1, underrun=1 (sticky until reset).
- Simultaneous events: a bank's empty mark from playback and a WAIT_BANK check in the same cycle are resolved as empty, so the FSM may proceed on the following cycle. UNLOAD never writes the bank being played.
- Playback buffer: two banks of N×NB, inferred as BRAM with one write port and one read port.

Test Plan:
- Reset held 5 cycles, then released, no stimulus -> all outputs 0, bin_ready=1 one cycle after release.
- 512 bins streamed with bin_valid=1 and bin_real=index -> 512 core writes at addresses 0..511, bin_ready low after the last bin, single core_start pulse once core_ready=1.
- Core model returns real=index, scale=0; then 512 strobes -> sample_out sequence 0,1,...,511, each with a one-cycle sample_valid, underrun=0.
- scale=2 with real=0x08000, 0x10000, -0x10000 -> sample_out 0x1FFFF (saturated), 0x1FFFF, 0x20000; real=0x00100 -> 0x00400.
- sample_strobe before the first frame completes -> sample_out=0, sample_valid=1, underrun=1, which stays 1 after later valid frames.
- Three frames back-to-back with slow strobes -> the third frame waits in WAIT_BANK until bank 0 drains, no bank is overwritten, and output order is preserved.
- reset=0 mid-UNLOAD -> core_read_enable=0 next cycle, banks empty, FSM in LOAD; the next full frame plays correctly.

Source files
------------

// File: rtl/interface_ifft_out.sv
// Inverse-FFT return path: loads a frame of bins into the shared FFT core, runs it inverse,
// unloads the saturated real part into a ping-pong bank and plays one sample per codec strobe.
module interface_ifft_out #(
    parameter int NB        = 18,
    parameter int LOG_DEPTH = 9,
    parameter int N         = 1 << LOG_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bin_valid,
    input  logic [NB-1:0]        bin_real,
    input  logic [NB-1:0]        bin_imag,
    output logic                 bin_ready,
    output logic                 core_start,
    output logic [3:0]           core_log_depth,
    output logic                 core_real_mode,
    output logic                 core_direction,
    input  logic                 core_ready,
    input  logic                 core_done,
    input  logic [3:0]           core_output_scaling,
    output logic [LOG_DEPTH-1:0] core_address,
    output logic                 core_write_enable,
    output logic [2*NB-1:0]      core_write_data,
    output logic                 core_read_enable,
    input  logic                 core_read_valid,
    input  logic [2*NB-1:0]      core_read_data,
    input  logic                 sample_strobe,
    output logic [NB-1:0]        sample_out,
    output logic                 sample_valid,
    output logic                 underrun
);

    typedef enum logic [2:0] {LOAD, START, WAIT_DONE, WAIT_BANK, UNLOAD} state_t;

    localparam logic [LOG_DEPTH-1:0] LAST = LOG_DEPTH'(N - 1);
    localparam int XW = NB + 16;
    localparam logic signed [XW-1:0] MAX_V = {{(XW-NB+1){1'b0}}, {(NB-1){1'b1}}};
    localparam logic signed [XW-1:0] MIN_V = {{(XW-NB+1){1'b1}}, {(NB-1){1'b0}}};

    state_t                 state_reg;
    logic [LOG_DEPTH-1:0]   load_idx_reg;
    logic [LOG_DEPTH-1:0]   play_idx_reg;
    logic [LOG_DEPTH-1:0]   core_addr_reg;
    logic [2*NB-1:0]        core_wdata_reg;
    logic                   bin_ready_reg, core_start_reg, core_we_reg, core_re_reg;
    logic [3:0]             scale_reg;
    logic                   fill_bank_reg, play_bank_reg;
    logic [1:0]             full_reg, full_next;
    logic [NB-1:0]          sample_reg;
    logic                   sample_valid_reg, underrun_reg;

    logic [NB-1:0]          bank_mem [0:2*N-1];

    logic signed [XW-1:0]   ext_real, shifted;
    logic [NB-1:0]          sat_value;
    logic                   unload_we, fill_done, play_hit, play_last;
    logic [LOG_DEPTH:0]     wr_addr, rd_addr;
    logic                   unused_imag;

    assign unused_imag = ^core_read_data[2*NB-1:NB];

    // Real part is sign-extended into a wide word so any shift up to 15 is exact before clamping.
    always_comb begin
        ext_real = {{(XW-NB){core_read_data[NB-1]}}, core_read_data[NB-1:0]};
        shifted  = ext_real <<< scale_reg;
        if (shifted > MAX_V)
            sat_value = MAX_V[NB-1:0];
        else if (shifted < MIN_V)
            sat_value = MIN_V[NB-1:0];
        else
            sat_value = shifted[NB-1:0];
    end

    assign unload_we = (state_reg == UNLOAD) && core_read_valid;
    assign fill_done = unload_we && (core_addr_reg == LAST);
    assign play_hit  = sample_strobe && full_reg[play_bank_reg];
    assign play_last = play_hit && (play_idx_reg == LAST);
    assign wr_addr   = {fill_bank_reg, core_addr_reg};
    assign rd_addr   = {play_bank_reg, play_idx_reg};

    // Fill and drain never target the same bank in one cycle: a bank is filled only while empty.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign full_next[gi] = (fill_done && fill_bank_reg == 1'(gi)) ? 1'b1 :
                                   (play_last && play_bank_reg == 1'(gi)) ? 1'b0 : full_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (unload_we)
            bank_mem[wr_addr] <= sat_value;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            full_reg         <= '0;
            play_idx_reg     <= '0;
            play_bank_reg    <= 1'b0;
            sample_reg       <= '0;
            sample_valid_reg <= 1'b0;
            underrun_reg     <= 1'b0;
        end else begin
            full_reg         <= full_next;
            sample_valid_reg <= sample_strobe;
            if (sample_strobe) begin
                if (play_hit) begin
                    sample_reg   <= bank_mem[rd_addr];
                    play_idx_reg <= play_idx_reg + 1'b1;
                    if (play_idx_reg == LAST)
                        play_bank_reg <= ~play_bank_reg;
                end else begin
                    sample_reg   <= '0;
                    underrun_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= LOAD;
            load_idx_reg   <= '0;
            bin_ready_reg  <= 1'b0;
            core_start_reg <= 1'b0;
            core_we_reg    <= 1'b0;
            core_re_reg    <= 1'b0;
            core_addr_reg  <= '0;
            core_wdata_reg <= '0;
            scale_reg      <= '0;
            fill_bank_reg  <= 1'b0;
        end else begin
            core_start_reg <= 1'b0;
            core_we_reg    <= 1'b0;
            case (state_reg)
                LOAD: begin
                    bin_ready_reg <= 1'b1;
                    if (bin_valid && bin_ready_reg) begin
                        core_we_reg    <= 1'b1;
                        core_wdata_reg <= {bin_imag, bin_real};
                        core_addr_reg  <= load_idx_reg;
                        load_idx_reg   <= load_idx_reg + 1'b1;
                        if (load_idx_reg == LAST) begin
                            bin_ready_reg <= 1'b0;
                            state_reg     <= START;
                        end
                    end
                end
                START: begin
                    if (core_ready) begin
                        core_start_reg <= 1'b1;
                        state_reg      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (core_done) begin
                        scale_reg <= core_output_scaling;
                        state_reg <= WAIT_BANK;
                    end
                end
                WAIT_BANK: begin
                    if (!full_reg[fill_bank_reg]) begin
                        core_addr_reg <= '0;
                        core_re_reg   <= 1'b1;
                        state_reg     <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (core_read_valid) begin
                        core_addr_reg <= core_addr_reg + 1'b1;
                        if (core_addr_reg == LAST) begin
                            core_re_reg   <= 1'b0;
                            fill_bank_reg <= ~fill_bank_reg;
                            bin_ready_reg <= 1'b1;
                            state_reg     <= LOAD;
                        end
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

    assign bin_ready         = bin_ready_reg;
    assign core_start        = core_start_reg;
    assign core_log_depth    = 4'(LOG_DEPTH);
    assign core_real_mode    = 1'b1;
    assign core_direction    = 1'b1;
    assign core_address      = core_addr_reg;
    assign core_write_enable = core_we_reg;
    assign core_write_data   = core_wdata_reg;
    assign core_read_enable  = core_re_reg;
    assign sample_out        = sample_reg;
    assign sample_valid      = sample_valid_reg;
    assign underrun          = underrun_reg;

endmodule

// File: tb/tb_interface_ifft_out.sv
// Bench for interface_ifft_out: identity FFT-core model, expected samples queued as bins are driven
// and popped as the block plays them out.
module tb_interface_ifft_out;

    localparam int NB        = 18;
    localparam int LOG_DEPTH = 9;
    localparam int N         = 512;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 bin_valid = 1'b0;
    logic [NB-1:0]        bin_real = '0;
    logic [NB-1:0]        bin_imag = '0;
    logic                 bin_ready;
    logic                 core_start;
    logic [3:0]           core_log_depth;
    logic                 core_real_mode;
    logic                 core_direction;
    logic                 core_ready = 1'b1;
    logic                 core_done = 1'b0;
    logic [3:0]           core_output_scaling;
    logic [LOG_DEPTH-1:0] core_address;
    logic                 core_write_enable;
    logic [2*NB-1:0]      core_write_data;
    logic                 core_read_enable;
    logic                 core_read_valid;
    logic [2*NB-1:0]      core_read_data;
    logic                 sample_strobe = 1'b0;
    logic [NB-1:0]        sample_out;
    logic                 sample_valid;
    logic                 underrun;

    int total = 0;
    int bad = 0;
    logic [NB-1:0]   frame_q[$];
    logic [NB-1:0]   samp_q[$];
    logic [2*NB-1:0] core_mem [N];
    logic [3:0]      core_scale = 4'd0;
    int wr_cnt = 0;
    int start_cnt = 0;
    int strobe_cnt = 0;
    int unload_starts = 0;
    int strobes_at_rise [8];
    logic prev_re = 1'b0;

    interface_ifft_out #(.NB(NB), .LOG_DEPTH(LOG_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .bin_valid(bin_valid), .bin_real(bin_real), .bin_imag(bin_imag), .bin_ready(bin_ready),
        .core_start(core_start), .core_log_depth(core_log_depth), .core_real_mode(core_real_mode),
        .core_direction(core_direction), .core_ready(core_ready), .core_done(core_done),
        .core_output_scaling(core_output_scaling), .core_address(core_address),
        .core_write_enable(core_write_enable), .core_write_data(core_write_data),
        .core_read_enable(core_read_enable), .core_read_valid(core_read_valid),
        .core_read_data(core_read_data), .sample_strobe(sample_strobe),
        .sample_out(sample_out), .sample_valid(sample_valid), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Identity core: reads return exactly what was written at that address.
    assign core_read_valid     = core_read_enable;
    assign core_read_data      = core_mem[core_address];
    assign core_output_scaling = core_scale;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] sat_model(input int v, input logic [3:0] sh);
        longint p;
        p = longint'(v) * (longint'(1) << sh);
        if (p > 131071) return 18'h1FFFF;
        if (p < -131072) return 18'h20000;
        return p[NB-1:0];
    endfunction

    function automatic int bin_val(input int kind, input int i);
        if (kind == 0) return i;
        if (kind == 1) begin
            case (i % 4)
                0: return 32'h08000;
                1: return 32'h10000;
                2: return -32'h10000;
                default: return 32'h00100;
            endcase
        end
        return ((i * 37 + kind * 1000) % 100000) - 50000;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (reset && core_start) begin
                start_cnt++;
                core_ready = 1'b0;
                repeat (4) @(negedge clk);
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
                core_ready = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset && core_write_enable) begin
                chk("wr_addr", 64'(core_address), 64'(wr_cnt));
                core_mem[core_address] = core_write_data;
                wr_cnt = (wr_cnt + 1) % N;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (core_read_enable && !prev_re) begin
                if (unload_starts < 8) strobes_at_rise[unload_starts] = strobe_cnt;
                unload_starts++;
            end
            prev_re = core_read_enable;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset && sample_valid) begin
                if (samp_q.size() == 0)
                    chk("extra_valid", 64'(sample_valid), 64'd0);
                else
                    chk("sample", 64'(sample_out), 64'(samp_q.pop_front()));
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (5) step();
        chk("rst_bin_ready", 64'(bin_ready), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_core_we", 64'(core_write_enable), 64'd0);
        chk("rst_core_re", 64'(core_read_enable), 64'd0);
        chk("rst_core_addr", 64'(core_address), 64'd0);
        chk("rst_core_wdata", 64'(core_write_data), 64'd0);
        chk("rst_sample_out", 64'(sample_out), 64'd0);
        chk("rst_sample_valid", 64'(sample_valid), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        frame_q.delete();
        samp_q.delete();
        reset = 1'b1;
        step();
        chk("bin_ready_after_rst", 64'(bin_ready), 64'd1);
    endtask

    task automatic send_frame(input int kind);
        int t;
        for (int i = 0; i < N; i++) begin
            bin_real  = NB'(bin_val(kind, i));
            bin_imag  = NB'($urandom);
            bin_valid = 1'b1;
            frame_q.push_back(sat_model(bin_val(kind, i), core_scale));
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bin_ready && t < 10000);
            if (!bin_ready) begin
                chk("bin_accept_timeout", 64'(bin_ready), 64'd1);
                bin_valid = 1'b0;
                return;
            end
            step();
        end
        bin_valid = 1'b0;
        $display("frame sent kind=%0d scale=%0d", kind, core_scale);
    endtask

    task automatic wait_unload();
        int t = 0;
        while (!core_read_enable && t < 10000) begin
            @(negedge clk);
            t++;
        end
        chk("unload_start", 64'(core_read_enable), 64'd1);
        t = 0;
        while (core_read_enable && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("unload_end", 64'(core_read_enable), 64'd0);
        step();
    endtask

    task automatic do_strobe(input bit expect_data);
        logic [NB-1:0] e = '0;
        if (expect_data && frame_q.size() > 0) e = frame_q.pop_front();
        samp_q.push_back(e);
        sample_strobe = 1'b1;
        strobe_cnt++;
        step();
        sample_strobe = 1'b0;
    endtask

    task automatic play(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            do_strobe(1'b1);
            repeat (gap) step();
        end
        repeat (3) step();
        $display("played %0d strobes, pending=%0d", n, samp_q.size());
    endtask

    initial begin
        for (int i = 0; i < N; i++) core_mem[i] = '0;

        // Reset state and constant core controls
        do_reset();
        chk("log_depth", 64'(core_log_depth), 64'd9);
        chk("real_mode", 64'(core_real_mode), 64'd1);
        chk("direction", 64'(core_direction), 64'd1);

        // Index frame, scale 0
        start_cnt = 0;
        core_scale = 4'd0;
        send_frame(0);
        chk("bin_ready_low_after_last", 64'(bin_ready), 64'd0);
        wait_unload();
        chk("single_start", 64'(start_cnt), 64'd1);
        play(N, 1);
        chk("frame0_drained", 64'(samp_q.size()), 64'd0);
        chk("no_underrun", 64'(underrun), 64'd0);

        // Saturation frame, scale 2
        core_scale = 4'd2;
        send_frame(1);
        wait_unload();
        play(N, 1);
        chk("sat_drained", 64'(samp_q.size()), 64'd0);
        chk("no_underrun_sat", 64'(underrun), 64'd0);

        // Strobe before any frame is ready
        do_reset();
        do_strobe(1'b0);
        chk("underrun_set", 64'(underrun), 64'd1);
        core_scale = 4'd0;
        send_frame(2);
        wait_unload();
        play(N, 1);
        chk("underrun_sticky", 64'(underrun), 64'd1);
        chk("frame2_drained", 64'(samp_q.size()), 64'd0);

        // Three back-to-back frames against slow strobes
        unload_starts = 0;
        strobe_cnt = 0;
        fork
            begin
                send_frame(3);
                send_frame(4);
                send_frame(5);
            end
            begin
                wait_unload();
                play(3 * N, 3);
            end
        join
        chk("three_unloads", 64'(unload_starts), 64'd3);
        chk("third_waits_for_bank", 64'(strobes_at_rise[2] >= N), 64'd1);
        chk("three_drained", 64'(samp_q.size()), 64'd0);

        // Reset in the middle of an unload
        send_frame(6);
        begin
            int t = 0;
            while (!core_read_enable && t < 10000) begin
                @(negedge clk);
                t++;
            end
            chk("mid_unload_reached", 64'(core_read_enable), 64'd1);
        end
        repeat (100) step();
        reset = 1'b0;
        step();
        chk("mid_rst_re_low", 64'(core_read_enable), 64'd0);
        chk("mid_rst_bin_ready", 64'(bin_ready), 64'd0);
        frame_q.delete();
        reset = 1'b1;
        step();
        chk("mid_rst_load", 64'(bin_ready), 64'd1);
        do_strobe(1'b0);
        chk("banks_empty_after_rst", 64'(underrun), 64'd1);
        send_frame(7);
        wait_unload();
        play(N, 1);
        chk("post_rst_drained", 64'(samp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
